led_scroller: RTL and testbench
===============================

# led_scroller

Message source for the 4-digit seven-segment display path. Holds a 16-entry message of 4-bit character codes and presents a 4-character sliding window on `char3..char0`; the existing anode multiplexer consumes these outputs directly. The window advances one position every `STEP_CYCLES` clocks while running. A board push-button toggles run/pause, and a write port loads message contents.

## Interface

**Parameters**
- `STEP_CYCLES`, default 50_000_000: clocks per scroll step; legal range ≥ 2.

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `btn` in 1: raw run/pause push-button; asynchronous to `clk`.
- `clr` in 1: synchronous clear of message, pointer and timer.
- `wr_en` in 1: write strobe for the message buffer.
- `wr_addr` in 4: message entry index, 0..15.
- `wr_data` in 4: character code; stored unmodified, including codes 13..15.
- `char3` out 4: leftmost digit, `msg[ptr]`.
- `char2` out 4: `msg[ptr+1]`.
- `char1` out 4: `msg[ptr+2]`.
- `char0` out 4: rightmost digit, `msg[ptr+3]`.
- `running` out 1: current run state.
- `step` out 1: high during the cycle in which `ptr` advances on the next edge.

## Operation

**Character codes** (decoder contract)
- 0..9 are digits.
- 10 is dash.
- 11 is "F".
- 12 is blank.
- 13..15 render as "F" downstream.

**State**
- `msg[0:15]`: 4-bit message entries.
- `ptr`: 4 bits.
- `timer`: `$clog2(STEP_CYCLES)` bits.
- `run`: 1 bit.
- Synchronizer flops `s1`, `s2`, `s3`.

**Reset values**
- Every `msg` entry = 12.
- `ptr` = 0, `timer` = 0, `run` = 1.
- `s1` = `s2` = `s3` = 0.
- Resulting outputs: `char3..char0` = 12, `running` = 1, `step` = 0.

**Window**
- `charN` = `msg[(ptr + 3 − N) mod 16]`.
- Outputs are a pure function of registers: no input-to-output combinational path.

**Timer**
- When `run`=1: `timer` increments each cycle and wraps from `STEP_CYCLES−1` to 0.
- When `run`=0: `timer` holds.
- `step` = `run && timer == STEP_CYCLES−1`.
- On an edge where `step`=1: `ptr` ← `ptr`+1, wrapping 15→0 so the message loops continuously.

**Button**
- Chain: `s1`←`btn`, `s2`←`s1`, `s3`←`s2`.
- `rise` = `s2 & ~s3`.
- `run` ← `run ^ rise`.
- Holding `btn` high toggles `run` once only; each new press toggles it again.

**Write**
- On an edge with `wr_en`=1: `msg[wr_addr]` ← `wr_data`.

**Clear**
- On an edge with `clr`=1: every `msg` entry ← 12, `ptr` ← 0, `timer` ← 0.
- `run` is unaffected.

**Priority and simultaneous events**
- `clr` overrides `wr_en` and `step` in the same cycle.
- `wr_en` together with `step`: both take effect on the same edge. The write targets the absolute address, independent of the pointer move.
- `rise` together with `step`: the step completes; `run` toggles on that same edge.
- Pausing while `timer` = k and resuming later continues the count from k.

**Reset mid-operation**
- Reset asserted at any time forces all reset values immediately, without waiting for a clock edge.
- Any in-progress step or write is discarded.

## Timing

- **Write latency:** a write sampled at edge E is visible on the `char` outputs immediately after E, when the address lies in the current window.
- **Step cadence:** with `run`=1 continuously from reset release, the first `ptr` advance occurs at the `STEP_CYCLES`-th rising edge. Later advances follow every `STEP_CYCLES` edges.
- **Button latency:** `btn` sampled high at edge E (low at E−1) toggles `run` at edge E+2, so `running` changes after E+2.
- **Minimum press width:** `btn` pulses shorter than one clock period may be missed. No debounce filtering beyond synchronization; mechanical debounce belongs to the board or a separate block.
- **Clear latency:** `clr` takes effect on the next edge; outputs read 12 after that edge.

## Structure

- **Package `led_pkg`**, holding:
  - `CHAR_DASH` = 4'd10
  - `CHAR_F` = 4'd11
  - `CHAR_BLANK` = 4'd12
  - `MSG_LEN` = 16
  - `char_t` = 4-bit character typedef
- **Sub-module `btn_sync_edge`**: 3-flop synchronizer plus rising-edge detector. Ports: `clk`, `reset`, `din`, `rise`.
- **Top level:** buffer, pointer, timer, run flop and window muxes stay in `led_scroller`.

## Test plan

All scenarios use `STEP_CYCLES`=4.

- **Reset:** assert `reset` mid-stream → `char3..0` = 12,12,12,12 immediately; `running`=1; `step`=0.
- **Load and scroll:** write `msg[0..5]` = 1,2,3,4,5,6 with `run` already 1 → window 1,2,3,4. `step` pulses every 4th cycle; window becomes 2,3,4,5, then 3,4,5,6.
- **Wrap-around:** after 13 steps (`ptr`=13), window = `msg[13]`,`msg[14]`,`msg[15]`,`msg[0]`. After 16 steps, `ptr`=0 and the window matches the initial window.
- **Button:** hold `btn` high for 10 cycles → `running` falls exactly 2 edges after first sampled high and stays 0; `ptr` and `timer` are frozen. A second press → `running`=1 and the count resumes from the frozen `timer` value.
- **Simultaneous write and step:** `wr_en` with `wr_addr` = `ptr`+4 and `wr_data`=10 on a `step` cycle → after the edge, `char0`=10.
- **Clear priority:** `clr`, `wr_en` and `step` high together → all outputs 12, `ptr`=0, `timer`=0, `running` unchanged.

Source files
------------

// File: rtl/led_pkg.sv
// Shared character codes and types for the seven-segment message path.
package led_pkg;

    typedef logic [3:0] char_t;

    localparam char_t CHAR_DASH  = 4'd10;
    localparam char_t CHAR_F     = 4'd11;
    localparam char_t CHAR_BLANK = 4'd12;
    localparam int    MSG_LEN    = 16;

endpackage

// File: rtl/btn_sync_edge.sv
// Three-flop synchronizer for an asynchronous push-button with a rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic s1_reg;
    logic s2_reg;
    logic s3_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= din;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    // s1 may go metastable; only the settled s2/s3 pair feeds the edge detector.
    assign rise = s2_reg & ~s3_reg;

endmodule

// File: rtl/led_scroller.sv
// 16-entry character message with a 4-character scrolling window, run/pause
// button and a write port for loading message contents.
module led_scroller
    import led_pkg::*;
#(
    parameter int STEP_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [3:0] char3,
    output logic [3:0] char2,
    output logic [3:0] char1,
    output logic [3:0] char0,
    output logic       running,
    output logic       step
);

    localparam int TIMER_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STEP_CYCLES - 1);

    char_t              msg_reg [MSG_LEN];
    logic [3:0]         ptr_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic               run_reg;
    logic               rise;
    logic               step_now;
    char_t              win [4];

    btn_sync_edge u_btn_sync_edge (
        .clk   (clk),
        .reset (reset),
        .din   (btn),
        .rise  (rise)
    );

    assign step_now = run_reg && (timer_reg == TIMER_LAST);

    // Flop-based buffer: every entry must return to blank on reset and clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_reg[i] <= CHAR_BLANK;
            end
        end else if (clr) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_reg[i] <= CHAR_BLANK;
            end
        end else if (wr_en) begin
            msg_reg[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg   <= 4'd0;
            timer_reg <= '0;
            run_reg   <= 1'b1;
        end else begin
            run_reg <= run_reg ^ rise;
            if (clr) begin
                ptr_reg   <= 4'd0;
                timer_reg <= '0;
            end else begin
                if (step_now) begin
                    ptr_reg <= ptr_reg + 4'd1;
                end
                if (run_reg) begin
                    timer_reg <= (timer_reg == TIMER_LAST) ? '0 : timer_reg + 1'b1;
                end
            end
        end
    end

    // Window position gi shows msg[ptr + 3 - gi]; the 4-bit sum wraps the message.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_window
            assign win[gi] = msg_reg[4'(ptr_reg + 4'(3 - gi))];
        end
    endgenerate

    assign char3   = win[3];
    assign char2   = win[2];
    assign char1   = win[1];
    assign char0   = win[0];
    assign running = run_reg;
    assign step    = step_now;

endmodule

// File: tb/tb_led_scroller.sv
// Directed bench for led_scroller with STEP_CYCLES = 4.
module tb_led_scroller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn = 1'b0;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [3:0] wr_data = 4'd0;
    logic [3:0] char3, char2, char1, char0;
    logic       running;
    logic       step;

    int checks = 0;
    int errors = 0;

    led_scroller #(.STEP_CYCLES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .char3   (char3),
        .char2   (char2),
        .char1   (char1),
        .char0   (char0),
        .running (running),
        .step    (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [3:0]  wr_addr;
        logic [3:0]  wr_data;
        logic [15:0] exp_chars;
        logic        exp_step;
    } vec_t;

    vec_t vecs [12];
    logic [3:0] exp_msg [16];

    function automatic logic [15:0] win_now();
        return {char3, char2, char1, char0};
    endfunction

    function automatic logic [15:0] model_win(int p);
        return {exp_msg[p % 16], exp_msg[(p + 1) % 16], exp_msg[(p + 2) % 16], exp_msg[(p + 3) % 16]};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [15:0] chars, input logic run_e, input logic step_e);
        check({name, " chars"}, win_now(), chars);
        check({name, " running"}, {15'd0, running}, {15'd0, run_e});
        check({name, " step"}, {15'd0, step}, {15'd0, step_e});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'd0, 4'd1,  16'h1CCC, 1'b0};
        vecs[1]  = '{1'b1, 4'd1, 4'd2,  16'h12CC, 1'b0};
        vecs[2]  = '{1'b1, 4'd2, 4'd3,  16'h123C, 1'b1};
        vecs[3]  = '{1'b1, 4'd3, 4'd4,  16'h234C, 1'b0};
        vecs[4]  = '{1'b1, 4'd4, 4'd5,  16'h2345, 1'b0};
        vecs[5]  = '{1'b1, 4'd5, 4'd6,  16'h2345, 1'b0};
        vecs[6]  = '{1'b0, 4'd0, 4'd0,  16'h2345, 1'b1};
        vecs[7]  = '{1'b0, 4'd0, 4'd0,  16'h3456, 1'b0};
        vecs[8]  = '{1'b1, 4'd5, 4'd15, 16'h345F, 1'b0};
        vecs[9]  = '{1'b1, 4'd6, 4'd14, 16'h345F, 1'b0};
        vecs[10] = '{1'b0, 4'd0, 4'd0,  16'h345F, 1'b1};
        vecs[11] = '{1'b0, 4'd0, 4'd0,  16'h45FE, 1'b0};
        for (int i = 0; i < 16; i++) exp_msg[i] = 4'd12;
        exp_msg[0] = 4'd1; exp_msg[1] = 4'd2; exp_msg[2] = 4'd3; exp_msg[3] = 4'd4;
        exp_msg[4] = 4'd5; exp_msg[5] = 4'd15; exp_msg[6] = 4'd14;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_state("reset", 16'hCCCC, 1'b1, 1'b0);

        // Load and scroll
        for (int i = 0; i < 12; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data;
            tick();
            $display("vec %0d wr_en %0d addr %0d data %0d chars %h step %0d",
                     i, vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data, win_now(), step);
            check_state($sformatf("vec%0d", i), vecs[i].exp_chars, 1'b1, vecs[i].exp_step);
        end
        wr_en = 1'b0;

        // Wrap-around: 13 more steps from ptr 3 back to ptr 0
        for (int c = 1; c <= 52; c++) begin
            int p;
            tick();
            p = (3 + c / 4) % 16;
            check($sformatf("wrap%0d chars", c), win_now(), model_win(p));
            check($sformatf("wrap%0d step", c), {15'd0, step}, {15'd0, (c % 4) == 3});
            if (p == 13 && (c % 4) == 0) check("wrap ptr13", win_now(), 16'hCCC1);
        end
        check("wrap ptr0", win_now(), 16'h1234);

        // Button held 10 cycles: running drops on the third edge and stays low
        btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_state($sformatf("hold%0d", k), 16'h1234, (k < 3), 1'b0);
        end
        btn = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_state($sformatf("paused%0d", k), 16'h1234, 1'b0, 1'b0);
        end

        // Second press resumes from frozen timer = 3
        btn = 1'b1;
        tick();
        btn = 1'b0;
        check_state("resume1", 16'h1234, 1'b0, 1'b0);
        tick();
        check_state("resume2", 16'h1234, 1'b0, 1'b0);
        tick();
        check_state("resume3", 16'h1234, 1'b1, 1'b1);
        tick();
        check_state("resume4", 16'h2345, 1'b1, 1'b0);

        // Write and step on the same edge
        tick();
        tick();
        tick();
        check_state("pre_wr_step", 16'h2345, 1'b1, 1'b1);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'd10;
        tick();
        wr_en = 1'b0;
        check_state("wr_step", 16'h345A, 1'b1, 1'b0);

        // Clear beats write and step
        tick();
        tick();
        tick();
        check_state("pre_clr", 16'h345A, 1'b1, 1'b1);
        clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'd7;
        tick();
        clr = 1'b0;
        check_state("clr", 16'hCCCC, 1'b1, 1'b0);
        wr_addr = 4'd0; wr_data = 4'd9;
        tick();
        wr_en = 1'b0;
        check_state("clr_t1", 16'h9CCC, 1'b1, 1'b0);
        tick();
        check_state("clr_t2", 16'h9CCC, 1'b1, 1'b0);
        tick();
        check_state("clr_t3", 16'h9CCC, 1'b1, 1'b1);

        // Pause, then asynchronous reset between edges
        btn = 1'b1;
        tick();
        btn = 1'b0;
        tick();
        tick();
        check({"pause_pre_rst", " running"}, {15'd0, running}, 16'd0);
        #2;
        reset = 1'b1;
        #1;
        check_state("async_reset", 16'hCCCC, 1'b1, 1'b0);
        tick();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
